hcf: RTL and testbench
======================

HCF -- requirements
Module: hcf

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits; SHALL be at least 2.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  reset; asynchronous, active-low.
REQ-004 Port: start  input  1  request; sampled on a rising edge of clk while idle.
REQ-005 Port: in1  input  WIDTH  first operand, unsigned; captured on the accepted start edge.
REQ-006 Port: in2  input  WIDTH  second operand, unsigned; captured on the accepted start edge.
REQ-007 Port: busy  output  1  high from the accepted start until completion.
REQ-008 Port: done  output  1  one-cycle completion pulse.
REQ-009 Port: HCF  output  WIDTH  highest common factor of the last completed operand pair.

Function
REQ-010 SHALL be an FSM with states IDLE, CALC and DONE.
- IDLE: start=1 captures in1/in2 into working registers a/b, moves to CALC, busy=1.
- CALC: each cycle evaluates a/b and either finishes or subtracts.
- DONE: one cycle; done=1, busy=0; then returns to IDLE.
REQ-011 CALC SHALL apply exactly one step per cycle.
- If a==b, a==0 or b==0: HCF <= (a==0 ? b : a); go to DONE.
- Else if a>b: a <= a-b.
- Else: b <= b-a.
REQ-012 Latency SHALL be S+2 rising edges from the start edge to the edge that raises done, where S is the number of subtraction steps; the operand pairs (8,8) and (x,0) give S=0.
REQ-013 Results SHALL be: HCF(0,0)=0, HCF(0,b)=b, HCF(a,0)=a.
REQ-014 Worst case for WIDTH=8 SHALL be (255,1): S=254.
REQ-015 HCF SHALL update only on the edge entering DONE and hold its value until the next completion.
REQ-016 start SHALL be ignored while busy=1 or while in DONE; in1/in2 changes after capture SHALL NOT affect the result in progress.
REQ-017 start held high continuously SHALL launch a new operation on the first IDLE cycle after each DONE.
REQ-018 All arithmetic SHALL be unsigned and WIDTH bits wide, with no overflow possible.

Reset
REQ-019 rst_n=0 SHALL immediately force state IDLE, busy=0, done=0, HCF=0 and working registers to 0, independent of clk.
REQ-020 Reset asserted mid-operation SHALL abort the operation with no done pulse; the first start after release SHALL behave as a fresh request.

Configuration
REQ-021 Macro HCF_LCM_EN, when defined:
- adds output port lcm, 2*WIDTH bits wide;
- lcm = in1*in2/HCF, computed after CALC by a shift-subtract divider, one bit per cycle;
- adds exactly 2*WIDTH cycles before DONE;
- lcm = 0 when either operand is 0;
- lcm resets to 0 and updates together with HCF.
REQ-022 Without HCF_LCM_EN: no lcm port, no divider logic, and the latency of REQ-012 applies.

Verification
REQ-023 Start (10,5) -> done 3 edges after the start edge (S=1); HCF=5; with the macro, lcm=10.
REQ-024 Start (18,24) -> S=3, HCF=6; start (12,4) -> HCF=4; start (8,2) -> HCF=2.
REQ-025 Start (7,5) -> S=4, HCF=1; start (8,8) -> S=0, done 2 edges after the start edge, HCF=8.
REQ-026 Start (0,9) -> HCF=9; start (0,0) -> HCF=0 (lcm=0 with the macro); start (255,1) -> HCF=1 after 256 edges.
REQ-027 Start (255,1), pulse start again mid-CALC with (6,4) -> second start ignored, HCF=1; then start (6,4) -> HCF=2.
REQ-028 Start (255,1), assert rst_n=0 mid-CALC -> outputs 0 at once, no done; after release, start (18,24) -> HCF=6.

Source files
------------

// File: rtl/hcf.sv
// hcf -- highest common factor of two unsigned operands by repeated subtraction.
//
// Handshake: start is sampled on a rising clk edge only while the FSM is in IDLE;
// that edge captures in1/in2 and raises busy. busy stays high until the result
// is ready; done then pulses for exactly one cycle (busy low in that cycle) and
// the FSM returns to IDLE. HCF holds the last completed result.
//
// Optional feature, macro HCF_LCM_EN: adds output lcm = in1*in2/HCF, produced by
// a restoring shift-subtract divider that runs for 2*WIDTH cycles after CALC.
// HCF and lcm update together on the edge entering DONE.
//
// The current FSM state is visible as the signal 'state' for checkers.

module hcf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             busy,
  output logic             done,
`ifdef HCF_LCM_EN
  output logic [2*WIDTH-1:0] lcm,
`endif
  output logic [WIDTH-1:0] HCF
);

  // Operands narrower than 2 bits make no sense for this datapath.
  if (WIDTH < 2) begin : g_width_check
    $error("hcf: WIDTH must be at least 2");
  end

`ifdef HCF_LCM_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd3
  } state_t;
`endif

  state_t state;
  state_t state_next;

  // Working registers for the subtractive algorithm.
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;

  // CALC terminates when the operands meet or one of them is zero.
  logic             finish;
  logic [WIDTH-1:0] gcd_val;

  // Termination test and the result it yields (a==0 selects b, covering 0,0).
  always_comb begin
    finish  = (a == b) || (a == '0) || (b == '0);
    gcd_val = (a == '0) ? b : a;
  end

`ifdef HCF_LCM_EN
  localparam int CNT_W = $clog2(2 * WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(2 * WIDTH - 1);

  // Original operands, kept for the product once CALC has consumed a/b.
  logic [WIDTH-1:0]   op1;
  logic [WIDTH-1:0]   op2;
  // Result of CALC, used as divisor and published as HCF at the end.
  logic [WIDTH-1:0]   gcd_r;
  // Divider: quo starts as the dividend and shifts quotient bits in from the right.
  logic [2*WIDTH-1:0] quo;
  logic [WIDTH-1:0]   rem;
  logic [CNT_W-1:0]   cnt;

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     rem_diff;
  logic               rem_ge;
  logic [WIDTH-1:0]   rem_next;
  logic [2*WIDTH-1:0] quo_next;
  logic               div_last;
  logic               zero_op;

  // One restoring-division step: bring in the next dividend bit, trial-subtract.
  always_comb begin
    prod     = {{WIDTH{1'b0}}, op1} * {{WIDTH{1'b0}}, op2};
    rem_sh   = {rem, quo[2*WIDTH-1]};
    rem_diff = rem_sh - {1'b0, gcd_r};
    rem_ge   = (rem_sh >= {1'b0, gcd_r});
    rem_next = rem_ge ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    quo_next = {quo[2*WIDTH-2:0], rem_ge};
    div_last = (cnt == LAST_STEP);
    zero_op  = (op1 == '0) || (op2 == '0);
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = CALC;
        end
      end
      CALC: begin
        if (finish) begin
`ifdef HCF_LCM_EN
          state_next = DIV;
`else
          state_next = DONE;
`endif
        end
      end
`ifdef HCF_LCM_EN
      DIV: begin
        if (div_last) begin
          state_next = DONE;
        end
      end
`endif
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Outputs decoded from the state.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      CALC: busy = 1'b1;
`ifdef HCF_LCM_EN
      DIV:  busy = 1'b1;
`endif
      DONE: done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // Subtractive HCF datapath: capture, one step per CALC cycle, publish result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a   <= '0;
      b   <= '0;
      HCF <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a <= in1;
            b <= in2;
          end
        end
        CALC: begin
          if (finish) begin
`ifndef HCF_LCM_EN
            HCF <= gcd_val;
`endif
          end else if (a > b) begin
            a <= a - b;
          end else begin
            b <= b - a;
          end
        end
`ifdef HCF_LCM_EN
        DIV: begin
          if (div_last) begin
            HCF <= gcd_r;
          end
        end
`endif
        default: begin
          a <= a;
        end
      endcase
    end
  end

`ifdef HCF_LCM_EN
  // LCM datapath: keep operands, then divide their product by the HCF.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op1   <= '0;
      op2   <= '0;
      gcd_r <= '0;
      quo   <= '0;
      rem   <= '0;
      cnt   <= '0;
      lcm   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op1 <= in1;
            op2 <= in2;
          end
        end
        CALC: begin
          if (finish) begin
            gcd_r <= gcd_val;
            quo   <= prod;
            rem   <= '0;
            cnt   <= '0;
          end
        end
        DIV: begin
          quo <= quo_next;
          rem <= rem_next;
          cnt <= cnt + 1'b1;
          if (div_last) begin
            // A zero operand means a zero product; the divisor may also be zero.
            lcm <= zero_op ? '0 : quo_next;
          end
        end
        default: begin
          cnt <= cnt;
        end
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_hcf.sv
// tb_hcf -- randomized and directed checking of hcf against a Euclidean model.
// Latency is counted inclusively: the start edge and the edge raising done both count.

module tb_hcf;

  localparam int W = 8;
`ifdef HCF_LCM_EN
  localparam int EXTRA = 2 * W;
`else
  localparam int EXTRA = 0;
`endif

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] in1;
  logic [W-1:0] in2;
  logic         busy;
  logic         done;
  logic [W-1:0] hcf_out;
`ifdef HCF_LCM_EN
  logic [2*W-1:0] lcm;
`endif

  hcf #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .in1   (in1),
    .in2   (in2),
    .busy  (busy),
    .done  (done),
`ifdef HCF_LCM_EN
    .lcm   (lcm),
`endif
    .HCF   (hcf_out)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [W-1:0]   hcf;
    logic [2*W-1:0] lcm;
    logic [31:0]    start_cyc;
    logic [31:0]    lat;
  } exp_t;

  exp_t exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] hold_hcf = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: Euclid by division. Subtraction steps equal the sum of the
  // quotients minus one (the last subtraction is replaced by the a==b stop).
  function automatic exp_t model(input int x, input int y, input int sc);
    exp_t e;
    int p, q, t, sum;
    longint prod;
    p = x; q = y; sum = 0;
    if (x == 0 || y == 0) begin
      e.hcf = W'((x == 0) ? y : x);
      e.lat = 32'(2 + EXTRA);
    end else begin
      while (q != 0) begin
        sum += p / q;
        t = p % q;
        p = q;
        q = t;
      end
      e.hcf = W'(p);
      e.lat = 32'(sum - 1 + 2 + EXTRA);
    end
    prod = longint'(x) * longint'(y);
    e.lcm = (e.hcf == 0) ? '0 : (2*W)'(prod / longint'(e.hcf));
    e.start_cyc = 32'(sc);
    return e;
  endfunction

  // Monitor: pop and compare on every done pulse; HCF must hold otherwise.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      hold_hcf = '0;
    end else if (done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'(done), 64'(0));
      end else begin
        e = exp_q.pop_front();
        check("hcf", 64'(hcf_out), 64'(e.hcf));
        check("latency", 64'(cyc - int'(e.start_cyc) + 1), 64'(e.lat));
        check("busy_in_done", 64'(busy), 64'(0));
`ifdef HCF_LCM_EN
        check("lcm", 64'(lcm), 64'(e.lcm));
`endif
        hold_hcf = e.hcf;
      end
    end else if (hcf_out !== hold_hcf) begin
      check("hcf_hold", 64'(hcf_out), 64'(hold_hcf));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((busy || done) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) check("idle_timeout", 64'(busy), 64'(0));
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) check("done_timeout", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic start_op(input int x, input int y);
    wait_idle();
    in1 = W'(x);
    in2 = W'(y);
    start = 1'b1;
    exp_q.push_back(model(x, y, cyc + 1));
    @(negedge clk);
    start = 1'b0;
    in1 = W'($urandom_range(0, 255));
    in2 = W'($urandom_range(0, 255));
  endtask

  task automatic run_op(input int x, input int y);
    start_op(x, y);
    wait_drain();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    exp_t e1;
    int n;
    int s2;
    rst_n = 1'b0;
    start = 1'b0;
    in1 = '0;
    in2 = '0;
    #1;
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_done", 64'(done), 64'(0));
    check("reset_hcf", 64'(hcf_out), 64'(0));
`ifdef HCF_LCM_EN
    check("reset_lcm", 64'(lcm), 64'(0));
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Directed pairs from the worked examples.
    run_op(10, 5);
    run_op(18, 24);
    run_op(12, 4);
    run_op(8, 2);
    run_op(7, 5);
    run_op(8, 8);
    run_op(0, 9);
    run_op(9, 0);
    run_op(0, 0);
    run_op(255, 1);
    run_op(1, 255);
    run_op(255, 255);

    // start pulsed mid-CALC must be ignored.
    start_op(255, 1);
    repeat (20) @(negedge clk);
    in1 = 8'd6;
    in2 = 8'd4;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_drain();
    run_op(6, 4);

    // start held high relaunches on the first IDLE cycle after DONE.
    wait_idle();
    in1 = 8'd12;
    in2 = 8'd4;
    start = 1'b1;
    e1 = model(12, 4, cyc + 1);
    exp_q.push_back(e1);
    s2 = int'(e1.start_cyc) + int'(e1.lat) + 1;
    exp_q.push_back(model(12, 4, s2));
    n = 0;
    while (cyc < s2 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    wait_drain();

    // Reset mid-CALC aborts with no done pulse.
    start_op(255, 1);
    repeat (30) @(negedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_done", 64'(done), 64'(0));
    check("abort_hcf", 64'(hcf_out), 64'(0));
`ifdef HCF_LCM_EN
    check("abort_lcm", 64'(lcm), 64'(0));
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (300) @(negedge clk);
    run_op(18, 24);

    // Randomized pairs, mixing full range and small values.
    for (int i = 0; i < 40; i++) begin
      if (i % 3 == 0) run_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
      else            run_op(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
    end

    wait_drain();
    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
